// File: rtl/l1_mem_arbiter_pkg.sv
// Shared widths and FSM encodings for the L1 memory arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin instead of D-side priority).
`ifndef IMEM_BLOCK_ADDR_SIZE
`define IMEM_BLOCK_ADDR_SIZE 8
`endif
`ifndef IBLOCK_SIZE_BITS
`define IBLOCK_SIZE_BITS 128
`endif

package l1_mem_arbiter_pkg;

    localparam int ARB_ADDR_W  = `IMEM_BLOCK_ADDR_SIZE;
    localparam int ARB_BLOCK_W = `IBLOCK_SIZE_BITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IC_BUSY = 2'd1,
        ST_DC_BUSY = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/l1_mem_arbiter.sv
// Arbitrates I-cache refills and D-cache refills/write-backs onto one memory port.
// ARB_ROUND_ROBIN_EN selects alternating grants; default gives the D-side priority.
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = `IMEM_BLOCK_ADDR_SIZE,
    parameter int BLOCK_W = `IBLOCK_SIZE_BITS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ic_req,
    input  logic [ADDR_W-1:0]  ic_addr,
    output logic               ic_ready,
    output logic [BLOCK_W-1:0] ic_rdata,
    input  logic               dc_req,
    input  logic               dc_we,
    input  logic [ADDR_W-1:0]  dc_addr,
    input  logic [BLOCK_W-1:0] dc_wdata,
    output logic               dc_ready,
    output logic [BLOCK_W-1:0] dc_rdata,
    output logic               mem_ren,
    output logic               mem_wen,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic               mem_ready,
    input  logic [BLOCK_W-1:0] mem_rdata
);

    arb_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic               we_q;
    logic               ic_ready_q, dc_ready_q;
    logic [BLOCK_W-1:0] ic_rdata_q, dc_rdata_q;
    logic               grant_ic, grant_dc;
    logic               idle, ic_done, dc_done;

    assign idle    = (state_q == ST_IDLE);
    assign ic_done = (state_q == ST_IC_BUSY) && mem_ready;
    assign dc_done = (state_q == ST_DC_BUSY) && mem_ready;

`ifdef ARB_ROUND_ROBIN_EN
    // last_dc_q=0 means IC was granted last, so a tie goes to DC
    logic last_dc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_dc_q <= 1'b0;
        end else if (idle && (ic_req || dc_req)) begin
            last_dc_q <= grant_dc;
        end
    end

    assign grant_dc = dc_req && (!ic_req || !last_dc_q);
`else
    assign grant_dc = dc_req;
`endif
    assign grant_ic = ic_req && !grant_dc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_dc) begin
                    state_d = ST_DC_BUSY;
                end else if (grant_ic) begin
                    state_d = ST_IC_BUSY;
                end
            end
            ST_IC_BUSY, ST_DC_BUSY: begin
                if (mem_ready) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        unique case (state_q)
            ST_IC_BUSY: mem_ren = 1'b1;
            ST_DC_BUSY: begin
                mem_ren = !we_q;
                mem_wen = we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ic_ready_q <= 1'b0;
            dc_ready_q <= 1'b0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            ic_ready_q <= ic_done;
            dc_ready_q <= dc_done;
            if (idle && grant_dc) begin
                addr_q  <= dc_addr;
                wdata_q <= dc_wdata;
                we_q    <= dc_we;
            end else if (idle && grant_ic) begin
                addr_q <= ic_addr;
                we_q   <= 1'b0;
            end
            if (ic_done) begin
                ic_rdata_q <= mem_rdata;
            end
            if (dc_done) begin
                dc_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ic_ready  = ic_ready_q;
    assign dc_ready  = dc_ready_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;

endmodule
